// File: rtl/mmc_cmd_tx_if.sv
// Command request channel between the command register block and mmc_cmd_tx.
// The register block is the master; the serialiser is the slave.
interface mmc_cmd_tx_if;
    logic        start_i;
    logic [5:0]  cmd_idx_i;
    logic [31:0] arg_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;

    modport master (
        output start_i, cmd_idx_i, arg_i, abort_i,
        input  busy_o, done_o
    );

    modport slave (
        input  start_i, cmd_idx_i, arg_i, abort_i,
        output busy_o, done_o
    );
endinterface

// File: rtl/mmc_cmd_tx.sv
// MMC/SD command token serialiser: start, transmission, index, argument, CRC7, end bit.
// Launches one bit per bit strobe and steers an external CRC7 generator.
module mmc_cmd_tx (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bit_stb_i,
    mmc_cmd_tx_if.slave req,
    input  logic [6:0]  crc_i,
    output logic        crc_clear_o,
    output logic        crc_enable_o,
    output logic        crc_bit_o,
    output logic        cmd_o,
    output logic        cmd_oe_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_CRC     = 3'd3;
    localparam logic [2:0] S_END     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]  state_q;
    logic [39:0] shift_q;
    logic [5:0]  cnt_q;
    logic [2:0]  crc_cnt_q;
    logic [5:0]  crc_q;
    logic        cmd_q;
    logic        oe_q;
    logic        done_q;
    logic        busy;

    assign busy         = (state_q != S_IDLE);
    assign req.busy_o   = busy;
    assign req.done_o   = done_q;
    assign cmd_o        = cmd_q;
    assign cmd_oe_o     = oe_q;

    // The generator is cleared on acceptance and absorbs each of the 40 covered
    // bits on the same strobe that launches it onto the line.
    assign crc_clear_o  = req.start_i & ~busy;
    assign crc_enable_o = bit_stb_i & ((state_q == S_ARMED) | (state_q == S_DATA));
    assign crc_bit_o    = shift_q[39];

    // NOTE: every register here is state, so all assignments are non-blocking;
    // the shift register is reset too, making its contents deterministic out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            crc_cnt_q <= '0;
            crc_q     <= '0;
            cmd_q     <= 1'b1;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                // A strobe in the acceptance cycle is deliberately ignored.
                if (req.start_i) begin
                    shift_q   <= {1'b0, 1'b1, req.cmd_idx_i, req.arg_i};
                    cnt_q     <= '0;
                    crc_cnt_q <= '0;
                    state_q   <= S_ARMED;
                end
            end else if (req.abort_i) begin
                state_q <= S_IDLE;
                oe_q    <= 1'b0;
                cmd_q   <= 1'b1;
            end else if (bit_stb_i) begin
                case (state_q)
                    S_ARMED: begin
                        cmd_q   <= shift_q[39];
                        oe_q    <= 1'b1;
                        shift_q <= {shift_q[38:0], 1'b0};
                        cnt_q   <= 6'd1;
                        state_q <= S_DATA;
                    end
                    S_DATA: begin
                        cmd_q   <= shift_q[39];
                        shift_q <= {shift_q[38:0], 1'b0};
                        if (cnt_q == 6'd39) begin
                            state_q <= S_CRC;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                    S_CRC: begin
                        // crc_i is only valid on the first CRC strobe; keep the rest locally.
                        if (crc_cnt_q == 3'd0) begin
                            cmd_q <= crc_i[6];
                            crc_q <= crc_i[5:0];
                        end else begin
                            cmd_q <= crc_q[5];
                            crc_q <= {crc_q[4:0], 1'b0};
                        end
                        if (crc_cnt_q == 3'd6) begin
                            state_q <= S_END;
                        end else begin
                            crc_cnt_q <= crc_cnt_q + 3'd1;
                        end
                    end
                    S_END: begin
                        cmd_q   <= 1'b1;
                        state_q <= S_RELEASE;
                    end
                    S_RELEASE: begin
                        oe_q    <= 1'b0;
                        cmd_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmc_cmd_tx.sv
// Directed bench for mmc_cmd_tx with a behavioural CRC7 generator on crc_i.
// Expected frames are the well-known CMD0/CMD8/CMD17 tokens.
module tb_mmc_cmd_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_stb;
    logic [6:0] crc;
    logic       crc_clear;
    logic       crc_enable;
    logic       crc_bit;
    logic       cmd;
    logic       cmd_oe;

    int errors = 0;
    int checks = 0;

    mmc_cmd_tx_if req ();

    mmc_cmd_tx dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bit_stb_i    (bit_stb),
        .req          (req),
        .crc_i        (crc),
        .crc_clear_o  (crc_clear),
        .crc_enable_o (crc_enable),
        .crc_bit_o    (crc_bit),
        .cmd_o        (cmd),
        .cmd_oe_o     (cmd_oe)
    );

    always #5 clk = ~clk;

    // CRC7 generator, polynomial x^7 + x^3 + 1.
    always @(posedge clk or posedge rst) begin
        if (rst)             crc <= '0;
        else if (crc_clear)  crc <= '0;
        else if (crc_enable) crc <= {crc[5:0], 1'b0} ^ ({7{crc[6] ^ crc_bit}} & 7'h09);
    end

    localparam logic [47:0] FRAME_CMD0  = 48'h40_0000_0000_95;
    localparam logic [47:0] FRAME_CMD8  = 48'h48_0000_01AA_87;
    localparam logic [47:0] FRAME_CMD17 = 48'h51_0000_0000_55;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge drive point; returns at the negedge of the done_o cycle.
    // mode 0: strobe every cycle; mode 1: gaps of 1, 3, then 7 cycles.
    task automatic run_frame(input string name, input logic [5:0] idx, input logic [31:0] arg,
                             input int mode, input bit poke, input bit stb_acc,
                             input logic [47:0] exp);
        logic [47:0] line;
        int          en_cnt;
        int          gap;
        bit          mid_bad;
        line    = '0;
        en_cnt  = 0;
        mid_bad = 1'b0;
        req.start_i   = 1'b1;
        req.cmd_idx_i = idx;
        req.arg_i     = arg;
        bit_stb       = stb_acc;
        #1;
        checks++;
        if (crc_clear !== 1'b1) begin
            errors++; $display("FAIL %s crc_clear at accept: got %b want 1", name, crc_clear);
        end
        @(negedge clk);
        req.start_i   = 1'b0;
        bit_stb       = 1'b0;
        req.cmd_idx_i = ~idx;
        req.arg_i     = ~arg;
        checks++;
        if (req.busy_o !== 1'b1 || req.done_o !== 1'b0 || cmd_oe !== 1'b0) begin
            errors++; $display("FAIL %s after accept: busy=%b done=%b oe=%b want 1 0 0",
                               name, req.busy_o, req.done_o, cmd_oe);
        end
        for (int k = 0; k < 49; k++) begin
            gap = (mode == 0) ? 1 : ((k < 16) ? 1 : ((k < 32) ? 3 : 7));
            repeat (gap - 1) @(negedge clk);
            bit_stb = 1'b1;
            if (poke && k == 10) begin
                req.start_i   = 1'b1;
                req.cmd_idx_i = 6'd8;
            end
            #1;
            if (crc_enable === 1'b1) en_cnt++;
            if (poke && k == 10) begin
                checks++;
                if (crc_clear !== 1'b0) begin
                    errors++; $display("FAIL %s crc_clear while busy: got %b want 0", name, crc_clear);
                end
            end
            @(negedge clk);
            bit_stb     = 1'b0;
            req.start_i = 1'b0;
            if (k < 48) begin
                line = {line[46:0], cmd};
                if (cmd_oe !== 1'b1 || req.busy_o !== 1'b1 || req.done_o !== 1'b0) mid_bad = 1'b1;
            end
        end
        checks++;
        if (line !== exp) begin
            errors++; $display("FAIL %s line bits: got %h want %h", name, line, exp);
        end
        checks++;
        if (en_cnt != 40) begin
            errors++; $display("FAIL %s crc_enable pulses: got %0d want 40", name, en_cnt);
        end
        checks++;
        if (mid_bad) begin
            errors++; $display("FAIL %s in-frame oe/busy/done: got a bad cycle want oe=1 busy=1 done=0", name);
        end
        checks++;
        if (req.done_o !== 1'b1 || req.busy_o !== 1'b0 || cmd_oe !== 1'b0 || cmd !== 1'b1) begin
            errors++; $display("FAIL %s release: done=%b busy=%b oe=%b cmd=%b want 1 0 0 1",
                               name, req.done_o, req.busy_o, cmd_oe, cmd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (cmd !== 1'b1 || cmd_oe !== 1'b0 || req.busy_o !== 1'b0 || req.done_o !== 1'b0) begin
            errors++; $display("FAIL reset_state: cmd=%b oe=%b busy=%b done=%b want 1 0 0 0",
                               cmd, cmd_oe, req.busy_o, req.done_o);
        end
        idle(2);
        rst = 1'b0;
        idle(2);
        req.start_i   = 1'b1;
        req.cmd_idx_i = 6'd0;
        req.arg_i     = 32'h0;
        @(negedge clk);
        req.start_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bit_stb = 1'b1;
            @(negedge clk);
            bit_stb = 1'b0;
        end
        bit_stb = 1'b1;
        rst     = 1'b1;
        #1;
        checks++;
        if (cmd !== 1'b1 || cmd_oe !== 1'b0 || req.busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_midframe: cmd=%b oe=%b busy=%b want 1 0 0",
                               cmd, cmd_oe, req.busy_o);
        end
        @(negedge clk);
        rst     = 1'b0;
        bit_stb = 1'b0;
        idle(1);
        run_frame("after_reset", 6'd0, 32'h0, 0, 1'b0, 1'b1, FRAME_CMD0);
    endtask

    task automatic test_cmd0();
        idle(3);
        run_frame("cmd0", 6'd0, 32'h0, 0, 1'b0, 1'b0, FRAME_CMD0);
    endtask

    task automatic test_back_to_back();
        idle(2);
        run_frame("cmd8", 6'd8, 32'h0000_01AA, 0, 1'b0, 1'b0, FRAME_CMD8);
        run_frame("cmd17_b2b", 6'd17, 32'h0, 0, 1'b0, 1'b0, FRAME_CMD17);
    endtask

    task automatic test_irregular();
        idle(2);
        run_frame("irregular", 6'd0, 32'h0, 1, 1'b1, 1'b0, FRAME_CMD0);
    endtask

    task automatic test_abort();
        logic [41:0] part;
        bit          done_seen;
        part      = '0;
        done_seen = 1'b0;
        idle(2);
        req.start_i   = 1'b1;
        req.cmd_idx_i = 6'd0;
        req.arg_i     = 32'h0;
        @(negedge clk);
        req.start_i = 1'b0;
        for (int k = 0; k < 42; k++) begin
            bit_stb = 1'b1;
            @(negedge clk);
            bit_stb = 1'b0;
            part = {part[40:0], cmd};
        end
        checks++;
        if (part !== FRAME_CMD0[47:6]) begin
            errors++; $display("FAIL abort_prefix: got %h want %h", part, FRAME_CMD0[47:6]);
        end
        bit_stb     = 1'b1;
        req.abort_i = 1'b1;
        @(negedge clk);
        bit_stb     = 1'b0;
        req.abort_i = 1'b0;
        checks++;
        if (cmd_oe !== 1'b0 || cmd !== 1'b1 || req.busy_o !== 1'b0 || req.done_o !== 1'b0) begin
            errors++; $display("FAIL abort_state: oe=%b cmd=%b busy=%b done=%b want 0 1 0 0",
                               cmd_oe, cmd, req.busy_o, req.done_o);
        end
        for (int k = 0; k < 8; k++) begin
            bit_stb = 1'b1;
            @(negedge clk);
            bit_stb = 1'b0;
            if (req.done_o !== 1'b0 || cmd_oe !== 1'b0) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++; $display("FAIL abort_quiet: got done/oe activity want none");
        end
        run_frame("after_abort", 6'd0, 32'h0, 0, 1'b0, 1'b0, FRAME_CMD0);
    endtask

    task automatic test_abort_idle();
        idle(2);
        req.start_i   = 1'b1;
        req.abort_i   = 1'b1;
        req.cmd_idx_i = 6'd17;
        req.arg_i     = 32'h0;
        @(negedge clk);
        req.start_i = 1'b0;
        req.abort_i = 1'b0;
        checks++;
        if (req.busy_o !== 1'b1) begin
            errors++; $display("FAIL abort_idle_start: busy got %b want 1", req.busy_o);
        end
        req.abort_i = 1'b1;
        @(negedge clk);
        req.abort_i = 1'b0;
        checks++;
        if (req.busy_o !== 1'b0 || req.done_o !== 1'b0) begin
            errors++; $display("FAIL abort_armed: busy=%b done=%b want 0 0", req.busy_o, req.done_o);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bit_stb       = 1'b0;
        req.start_i   = 1'b0;
        req.abort_i   = 1'b0;
        req.cmd_idx_i = '0;
        req.arg_i     = '0;
        test_reset();
        test_cmd0();
        test_back_to_back();
        test_irregular();
        test_abort();
        test_abort_idle();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mmc_cmd_tx.md
# mmc_cmd_tx

Serialises one MMC/SD command token (start bit, transmission bit, 6-bit index, 32-bit argument, CRC7, end bit) onto the CMD line, one bit per MMC bit strobe. Drives the clear/enable/bit inputs of the CRC7 generator and consumes its 7-bit result to append the CRC. It sits between the command register block and the CMD pad.

## Interface
- No parameters. Frame length is fixed at 48 bits: 40 CRC-covered bits, 7 CRC bits, 1 end bit.
- clk_i  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-high
- bit_stb_i  input  1  one-cycle pulse per MMC bit period; the CMD line changes only on this pulse
- start_i  input  1  request to send; accepted only while busy_o=0
- cmd_idx_i  input  6  command index, sampled on acceptance
- arg_i  input  32  command argument, sampled on acceptance
- abort_i  input  1  synchronous abort; returns the block to IDLE
- crc_i  input  7  current CRC7 register value from the CRC7 generator
- crc_clear_o  output  1  CRC7 clear; combinational, equals start_i & ~busy_o
- crc_enable_o  output  1  CRC7 shift enable; combinational, equals bit_stb_i while state is ARMED or DATA
- crc_bit_o  output  1  bit fed to CRC7; equals the frame bit being launched (shift_q[39])
- cmd_o  output  1  CMD line data; reset value 1
- cmd_oe_o  output  1  CMD line output enable; reset value 0
- busy_o  output  1  1 from the acceptance edge until return to IDLE; reset value 0
- done_o  output  1  one-cycle pulse when the frame completes; reset value 0

## Operation
- Acceptance: in IDLE with start_i=1, the edge loads shift_q[39:0] = {1'b0, 1'b1, cmd_idx_i, arg_i} and sets cnt=0, and the state becomes ARMED. crc_clear_o is high in that same cycle.
- States and the action on each bit_stb_i:
  - ARMED: launch bit 0 (the start bit, 0). Set cmd_oe_o=1. Go to DATA with cnt=1.
  - DATA: launch shift_q[39], shift left, cnt++. After the strobe that launches bit 39 (cnt==39), go to CRC.
  - CRC: on the first strobe, launch crc_i[6] and latch crc_i[5:0] into a local register. On the next 6 strobes, launch the remaining bits MSB first. Then go to END.
  - END: launch 1 (the end bit). Go to RELEASE.
  - RELEASE: set cmd_oe_o=0 and cmd_o=1, pulse done_o for one cycle, go to IDLE.
- In DATA and ARMED, crc_bit_o is the bit launched on that strobe, so the CRC7 generator absorbs bit k at strobe k. crc_i therefore holds the CRC of all 40 bits at the first CRC-state strobe.
- With no bit_stb_i, all registers hold.
- start_i while busy_o=1 is ignored. No queuing.
- abort_i=1 in any non-IDLE state:
  - Next edge: state IDLE, cmd_oe_o=0, cmd_o=1, busy_o=0.
  - done_o is not pulsed.
  - abort_i takes priority over bit_stb_i in the same cycle.
  - abort_i in IDLE has no effect. If abort_i and start_i are both asserted in IDLE, the start is accepted.
- cmd_idx_i and arg_i changing after acceptance has no effect on the frame in flight.

## Timing
- Reset (asynchronous): state IDLE, cmd_o=1, cmd_oe_o=0, busy_o=0, done_o=0, cnt=0.
- A bit_stb_i in the acceptance cycle itself is not counted. The first bit launches on the first strobe after ARMED is entered.
- Frame on the line: 48 strobes (strobe 0 to strobe 47) after entering ARMED. cmd_o is registered, so each bit appears one clk_i cycle after its strobe.
- Release and done_o: on the 49th strobe. done_o is high in the cycle after that strobe edge; busy_o falls in the same cycle.
- Back-to-back: start_i may be accepted in the cycle where done_o=1 (state is already IDLE).
- cnt is 6 bits and counts 0 to 39 in DATA. A 3-bit counter counts the 7 CRC bits. Neither counter wraps.

## Test plan
- Reset mid-frame (assert rst_i at strobe 20) -> outputs immediately return to cmd_o=1, cmd_oe_o=0, busy_o=0. The next start produces a clean frame.
- CMD0, arg 0x00000000 -> line bits 0x40 00 00 00 00 95 MSB first, CRC 0x4A, done_o on the 49th strobe.
- CMD8, arg 0x000001AA -> 0x48 00 00 01 AA 87 (CRC 0x43). CMD17, arg 0 -> 0x51 00 00 00 00 55 (CRC 0x2A), sent back-to-back with start_i asserted in the done_o cycle.
- Irregular strobes (bit_stb_i every 1, 3, then 7 cycles) with start_i pulsed while busy -> identical CMD0 frame, second start ignored, crc_enable_o pulsed exactly 40 times.
- abort_i at the strobe launching CRC bit 2 -> next edge cmd_oe_o=0, cmd_o=1, busy_o=0, no done_o. The following CMD0 frame is still correct because crc_clear_o fires at the new acceptance.
